// File: rtl/glb_interrupt_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// global_buffer_param / global_buffer_pkg : shared GLB sizing and register map
// Revision: 1.0
// ---------------------------------------------------------------------------
package global_buffer_param;
  localparam int NUM_GLB_TILES  = 16;
  localparam int AXI_ADDR_WIDTH = 12;
  localparam int AXI_DATA_WIDTH = 32;
endpackage

package global_buffer_pkg;
  typedef logic [7:0] reg_ofs_t;

  localparam reg_ofs_t REG_IER         = 8'h00;
  localparam reg_ofs_t REG_ISR_F2G     = 8'h04;
  localparam reg_ofs_t REG_ISR_G2F     = 8'h08;
  localparam reg_ofs_t REG_ISR_PCFG    = 8'h0C;
  localparam reg_ofs_t REG_ISR_SUMMARY = 8'h10;

  localparam int IER_F2G_BIT  = 0;
  localparam int IER_G2F_BIT  = 1;
  localparam int IER_PCFG_BIT = 2;
  localparam int IER_WIDTH    = 3;
endpackage
`default_nettype wire

// File: rtl/glb_interrupt_ctrl_isr_w1c.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glb_isr_w1c : sticky set / write-1-to-clear status vector with level irq
// Revision: 1.0
// ---------------------------------------------------------------------------
module glb_isr_w1c #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pulse,
  input  logic [WIDTH-1:0] clr,
  input  logic             en,
  output logic [WIDTH-1:0] status,
  output logic             irq
);
  logic [WIDTH-1:0] status_d, status_q;
  logic             irq_d, irq_q;

  // Set dominates clear so a completion racing with software ack is never lost.
  always_comb begin
    status_d = pulse | (status_q & ~clr);
    irq_d    = en & (|status_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign status = status_q;
  assign irq    = irq_q;
endmodule
`default_nettype wire

// File: rtl/glb_interrupt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glb_interrupt_ctrl : aggregates per-tile GLB done pulses into host interrupts
// Revision: 1.0
// ---------------------------------------------------------------------------
module glb_interrupt_ctrl
  import global_buffer_pkg::*;
#(
  parameter int NUM_GLB_TILES  = global_buffer_param::NUM_GLB_TILES,
  parameter int AXI_ADDR_WIDTH = global_buffer_param::AXI_ADDR_WIDTH,
  parameter int AXI_DATA_WIDTH = global_buffer_param::AXI_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_GLB_TILES-1:0]  strm_f2g_interrupt_pulse,
  input  logic [NUM_GLB_TILES-1:0]  strm_g2f_interrupt_pulse,
  input  logic [NUM_GLB_TILES-1:0]  pcfg_g2f_interrupt_pulse,
  input  logic                      if_wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] if_wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0] if_wr_data,
  input  logic                      if_rd_en,
  input  logic [AXI_ADDR_WIDTH-1:0] if_rd_addr,
  output logic [AXI_DATA_WIDTH-1:0] if_rd_data,
  output logic                      if_rd_data_valid,
  output logic                      strm_f2g_interrupt,
  output logic                      strm_g2f_interrupt,
  output logic                      pcfg_g2f_interrupt,
  output logic                      glb_interrupt
);
  localparam int NT = NUM_GLB_TILES;

  function automatic logic reg_hit(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                   input reg_ofs_t ofs);
    return {addr[AXI_ADDR_WIDTH-1:2], 2'b00} == AXI_ADDR_WIDTH'(ofs);
  endfunction

  logic [IER_WIDTH-1:0]      ier_d, ier_q;
  logic [AXI_DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                      rd_valid_d, rd_valid_q;
  logic [NT-1:0]             isr_f2g, isr_g2f, isr_pcfg;
  logic [NT-1:0]             clr_f2g, clr_g2f, clr_pcfg;
  logic [AXI_DATA_WIDTH-1:0] rd_word;
  logic                      unused_ok;

  always_comb begin
    clr_f2g  = (if_wr_en && reg_hit(if_wr_addr, REG_ISR_F2G))  ? if_wr_data[NT-1:0] : '0;
    clr_g2f  = (if_wr_en && reg_hit(if_wr_addr, REG_ISR_G2F))  ? if_wr_data[NT-1:0] : '0;
    clr_pcfg = (if_wr_en && reg_hit(if_wr_addr, REG_ISR_PCFG)) ? if_wr_data[NT-1:0] : '0;

    ier_d = ier_q;
    if (if_wr_en && reg_hit(if_wr_addr, REG_IER)) begin
      ier_d = if_wr_data[IER_WIDTH-1:0];
    end
  end

  glb_isr_w1c #(.WIDTH(NT)) u_isr_f2g (
    .clk    (clk),
    .reset_n(reset_n),
    .pulse  (strm_f2g_interrupt_pulse),
    .clr    (clr_f2g),
    .en     (ier_q[IER_F2G_BIT]),
    .status (isr_f2g),
    .irq    (strm_f2g_interrupt)
  );

  glb_isr_w1c #(.WIDTH(NT)) u_isr_g2f (
    .clk    (clk),
    .reset_n(reset_n),
    .pulse  (strm_g2f_interrupt_pulse),
    .clr    (clr_g2f),
    .en     (ier_q[IER_G2F_BIT]),
    .status (isr_g2f),
    .irq    (strm_g2f_interrupt)
  );

  glb_isr_w1c #(.WIDTH(NT)) u_isr_pcfg (
    .clk    (clk),
    .reset_n(reset_n),
    .pulse  (pcfg_g2f_interrupt_pulse),
    .clr    (clr_pcfg),
    .en     (ier_q[IER_PCFG_BIT]),
    .status (isr_pcfg),
    .irq    (pcfg_g2f_interrupt)
  );

  // Reads sample pre-update state, so a same-cycle write is not visible.
  always_comb begin
    rd_word = '0;
    if (reg_hit(if_rd_addr, REG_IER)) begin
      rd_word = AXI_DATA_WIDTH'(ier_q);
    end else if (reg_hit(if_rd_addr, REG_ISR_F2G)) begin
      rd_word = AXI_DATA_WIDTH'(isr_f2g);
    end else if (reg_hit(if_rd_addr, REG_ISR_G2F)) begin
      rd_word = AXI_DATA_WIDTH'(isr_g2f);
    end else if (reg_hit(if_rd_addr, REG_ISR_PCFG)) begin
      rd_word = AXI_DATA_WIDTH'(isr_pcfg);
    end else if (reg_hit(if_rd_addr, REG_ISR_SUMMARY)) begin
      rd_word = AXI_DATA_WIDTH'({|isr_pcfg, |isr_g2f, |isr_f2g});
    end
    rd_valid_d = if_rd_en;
    rd_data_d  = if_rd_en ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ier_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ier_q      <= ier_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign if_rd_data       = rd_data_q;
  assign if_rd_data_valid = rd_valid_q;
  assign glb_interrupt    = strm_f2g_interrupt | strm_g2f_interrupt | pcfg_g2f_interrupt;

  assign unused_ok = ^{1'b0, if_wr_data, if_wr_addr[1:0], if_rd_addr[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_glb_interrupt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_glb_interrupt_ctrl : directed scoreboard bench for glb_interrupt_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_glb_interrupt_ctrl;
  localparam int NT = 16;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NT-1:0] f2g_p, g2f_p, pcfg_p;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, f2g_irq, g2f_irq, pcfg_irq, glb_irq;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  glb_interrupt_ctrl #(
    .NUM_GLB_TILES (NT),
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .strm_f2g_interrupt_pulse(f2g_p),
    .strm_g2f_interrupt_pulse(g2f_p),
    .pcfg_g2f_interrupt_pulse(pcfg_p),
    .if_wr_en                (wr_en),
    .if_wr_addr              (wr_addr),
    .if_wr_data              (wr_data),
    .if_rd_en                (rd_en),
    .if_rd_addr              (rd_addr),
    .if_rd_data              (rd_data),
    .if_rd_data_valid        (rd_valid),
    .strm_f2g_interrupt      (f2g_irq),
    .strm_g2f_interrupt      (g2f_irq),
    .pcfg_g2f_interrupt      (pcfg_irq),
    .glb_interrupt           (glb_irq)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic irqs(input string name, input logic [3:0] e);
    check(name, {28'd0, glb_irq, pcfg_irq, g2f_irq, f2g_irq}, {28'd0, e});
  endtask

  // Monitor: every valid read response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected_valid", {31'd0, rd_valid}, 32'd0);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end else begin
        check("rd_idle_data", rd_data, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    f2g_p = '0; g2f_p = '0; pcfg_p = '0;
    wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: reset state
    irqs("reset_irqs", 4'b0000);
    rd(12'h000, 32'h0);
    rd(12'h004, 32'h0);
    rd(12'h008, 32'h0);
    rd(12'h00C, 32'h0);
    rd(12'h010, 32'h0);

    // 2: f2g bit 3 with all types enabled, then W1C
    wr(12'h000, 32'h7);
    f2g_p = 16'h0008;
    tick();
    f2g_p = '0;
    irqs("f2g_set", 4'b1001);
    rd(12'h004, 32'h8);
    wr(12'h004, 32'h8);
    irqs("f2g_cleared", 4'b0000);

    // 3: masked pcfg, then enable
    wr(12'h000, 32'h0);
    pcfg_p = 16'h8000;
    tick();
    pcfg_p = '0;
    irqs("pcfg_masked", 4'b0000);
    rd(12'h00C, 32'h8000);
    wr(12'h000, 32'h4);
    irqs("pcfg_ier_lat", 4'b0000);
    tick();
    irqs("pcfg_enabled", 4'b1100);

    // 4: set beats clear on same bit
    wr(12'h000, 32'h6);
    g2f_p = 16'h0003;
    tick();
    g2f_p = '0;
    irqs("g2f_set", 4'b1110);
    wr_en = 1'b1; wr_addr = 12'h008; wr_data = 32'h3; g2f_p = 16'h0001;
    tick();
    wr_en = 1'b0; g2f_p = '0;
    irqs("g2f_set_wins", 4'b1110);
    rd(12'h008, 32'h1);

    // 5: summary, unmapped access, back-to-back and simultaneous rd/wr
    wr(12'h00C, 32'h8000);
    wr(12'h008, 32'h1);
    irqs("all_cleared", 4'b0000);
    f2g_p = 16'h0001; g2f_p = 16'h0002;
    tick();
    f2g_p = '0; g2f_p = '0;
    irqs("f2g_masked_g2f_on", 4'b1010);
    rd(12'h010, 32'h3);
    rd(12'h020, 32'h0);
    wr(12'h020, 32'hFFFF_FFFF);
    rd_en = 1'b1;
    rd_addr = 12'h000; exp_q.push_back(32'h6);    tick();
    rd_addr = 12'h004; exp_q.push_back(32'h1);    tick();
    rd_addr = 12'h00B; exp_q.push_back(32'h2);    tick();
    rd_addr = 12'h00C; exp_q.push_back(32'h0);    tick();
    rd_addr = 12'h010; exp_q.push_back(32'h3);    tick();
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = 12'h000; wr_data = 32'hFFFF_FFFF;
    rd(12'h000, 32'h6);
    wr_en = 1'b0;
    rd(12'h000, 32'h7);
    irqs("f2g_reenabled", 4'b1011);

    // 6: asynchronous reset during an in-flight read
    f2g_p = 16'hFFFF; g2f_p = 16'hFFFF; pcfg_p = 16'hFFFF;
    tick();
    f2g_p = '0; g2f_p = '0; pcfg_p = '0;
    irqs("all_set", 4'b1111);
    rd_en = 1'b1; rd_addr = 12'h004;
    #2 reset_n = 1'b0;
    #1;
    irqs("async_reset_irqs", 4'b0000);
    check("async_reset_valid", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    irqs("post_reset_irqs", 4'b0000);
    rd(12'h000, 32'h0);
    rd(12'h004, 32'h0);
    rd(12'h008, 32'h0);
    rd(12'h00C, 32'h0);
    rd(12'h010, 32'h0);

    repeat (3) tick();
    check("rd_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
